ring_out_arbiter: RTL

Output-port arbiter for one link of the ring router. It shares a single outgoing channel between two requesters: the ring pass-through input and the local PE injection path from the NIC. Two single-entry output buffers, one per virtual channel (VC0 even, VC1 odd), are used. The buffers alternate between being filled internally and being drained onto the link, under the global `net_polarity` signal.

---
 rtl/ring_out_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/ring_out_arbiter.sv
// Ring router output-port arbiter: ring pass-through and PE injection share one link
// through two single-entry VC buffers that alternate fill/drain under net_polarity.
module ring_out_arbiter #(
  parameter int DATA_W  = 64,
  parameter int VC_BIT  = 63,
  parameter int HOP_LSB = 48,
  parameter int HOP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              net_polarity,
  input  logic              ring_req,
  input  logic [DATA_W-1:0] ring_data,
  output logic              ring_gnt,
  input  logic              pe_req,
  input  logic [DATA_W-1:0] pe_data,
  output logic              pe_gnt,
  output logic              out_so,
  output logic [DATA_W-1:0] out_do,
  input  logic              out_ro,
  output logic [1:0]        vc_full,
  output logic [15:0]       sent_count
);

  logic [1:0]        vc_full_q, vc_full_d;
  logic [1:0]        prio_q, prio_d;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [15:0]       sent_q, sent_d;

  logic              int_vc, ext_vc;
  logic              ring_elig, pe_elig, ring_win, pe_win, drain;
  logic [DATA_W-1:0] ring_xf, cap_data, ext_buf;

  assign ext_vc = net_polarity;
  assign int_vc = ~net_polarity;

  // A requester whose VC bit targets the draining buffer is invisible to arbitration.
  always_comb begin
    ring_elig = !reset && ring_req && (ring_data[VC_BIT] == int_vc) && !vc_full_q[int_vc];
    pe_elig   = !reset && pe_req   && (pe_data[VC_BIT]   == int_vc) && !vc_full_q[int_vc];
    ring_win  = ring_elig && (!pe_elig   || !prio_q[int_vc]);
    pe_win    = pe_elig   && (!ring_elig ||  prio_q[int_vc]);
  end

  // Each ring traversal halves the hop field.
  always_comb begin
    ring_xf = ring_data;
    ring_xf[HOP_LSB +: HOP_W] = ring_data[HOP_LSB +: HOP_W] >> 1;
  end

  assign cap_data = ring_win ? ring_xf : pe_data;
  assign ext_buf  = ext_vc ? buf1_q : buf0_q;

  assign ring_gnt   = ring_win;
  assign pe_gnt     = pe_win;
  assign out_so     = !reset && vc_full_q[ext_vc];
  assign out_do     = out_so ? ext_buf : '0;
  assign drain      = out_so && out_ro;
  assign vc_full    = vc_full_q;
  assign sent_count = sent_q;

  // Fill and drain hit different buffers, so both updates can apply in one cycle.
  always_comb begin
    vc_full_d = vc_full_q;
    prio_d    = prio_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    sent_d    = sent_q;
    if (ring_win || pe_win) begin
      vc_full_d[int_vc] = 1'b1;
      prio_d[int_vc]    = ring_win;
      if (int_vc) buf1_d = cap_data;
      else        buf0_d = cap_data;
    end
    if (drain) begin
      vc_full_d[ext_vc] = 1'b0;
      sent_d            = sent_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vc_full_q <= 2'b00;
      prio_q    <= 2'b00;
      buf0_q    <= '0;
      buf1_q    <= '0;
      sent_q    <= 16'd0;
    end else begin
      vc_full_q <= vc_full_d;
      prio_q    <= prio_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      sent_q    <= sent_d;
    end
  end

endmodule
